muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register-file read-port values (rs1 data, rs2 data) and returns a 32-bit result that is written back to rd through the register file's write port.
- Operands and operation are latched on start, so the register-file address inputs may change freely while the unit is busy.
- Used by the control FSM as a multicycle functional unit with a start/done handshake.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- ITERATIONS, 32, shift-add / restoring-divide steps per operation. Must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset: asserted when 0, deasserted when 1; released synchronously by the system
- start  input  1  request strobe; sampled only in IDLE
- op  input  3  funct3 encoding: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111
- rs1_data  input  32  operand A, register-file read port 1
- rs2_data  input  32  operand B, register-file read port 2
- busy  output  1  high in every non-IDLE state
- done  output  1  single-cycle completion pulse
- result  output  32  registered result; holds its value until the next accepted start or reset

Behaviour:
- States (defined in the package): IDLE, CALC, FIXUP, DONE.
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, counter=0, all internal operand/accumulator registers=0.
- A reset mid-operation aborts the operation with no partial result.
- Accept (edge 0): IDLE with start=1.
  - Latch op, rs1_data, rs2_data.
  - Record operand signs: signed operands for MULH/DIV/REM; only A signed for MULHSU; none for the rest.
  - Convert signed operands to magnitudes.
  - start in CALC/FIXUP/DONE is ignored and has no effect on the running operation.
- Special cases, detected at accept, bypass CALC and go straight to DONE:
  - result loaded at edge 0, done=1 for the following cycle.
  - Divide by zero (divisor==0): DIV/DIVU result=0xFFFFFFFF; REM/REMU result=dividend unchanged.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV result=0x80000000, REM result=0.
- CALC, edges 1..32, one iteration per edge, counter 0..31:
  - Multiply: radix-2 shift-add into a 64-bit product.
  - Divide: restoring division, 32-bit quotient plus remainder.
  - After the edge with counter==31, go to FIXUP.
- FIXUP (edge 33):
  - Negate the product when the operand signs differ.
  - Negate the quotient when the operand signs differ.
  - Give the remainder the dividend's sign.
  - Select the low 32 bits (MUL) or high 32 bits (MULH*), quotient, or remainder.
  - Register the selection into result; go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle; next edge returns to IDLE.
- Latency: normal operations raise done in the cycle after edge 33 (34 cycles accept-to-done inclusive); special cases raise done in the cycle after edge 0.
- result stays stable from DONE until the next accept, including while in IDLE.
- All arithmetic is two's complement, with no saturation and no exceptions. MUL ignores signedness: low 32 bits are identical.

Decomposition:
- pkg_muldiv holds:
  - muldiv_op_t enum (funct3 values above)
  - muldiv_state_t enum (IDLE, CALC, FIXUP, DONE)
  - constants MULDIV_DIVZERO_Q=32'hFFFFFFFF and MULDIV_OVF_Q=32'h80000000
- The control FSM imports pkg_muldiv to drive op.
- One sub-module, muldiv_step: combinational single iteration that takes {acc, operand, mode} and returns the next {acc, operand}. It is instantiated once and reused every CALC cycle.

Test Plan:
1. MUL A=7, B=0xFFFFFFFD (-3) -> result=0xFFFFFFEB; done seen exactly 34 cycles after accept; busy high throughout.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIVU 0x80000000/0 -> 0xFFFFFFFF; done the cycle after accept.
5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; done the cycle after accept.
6. Start MUL 3×4, then:
   - pulse start again with DIV at cycle 10 while changing rs1/rs2 -> ignored; result=12 at done.
   - start a new MUL and assert reset=0 at cycle 15 -> busy=0, done=0, result=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/pkg_muldiv.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package pkg_muldiv;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } muldiv_state_t;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } muldiv_mode_t;

   localparam logic [31:0] MULDIV_DIVZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] MULDIV_OVF_Q     = 32'h8000_0000;

   function automatic logic op_a_signed(input muldiv_op_t op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_b_signed(input muldiv_op_t op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
module muldiv_step
   import pkg_muldiv::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  muldiv_mode_t      mode_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [XLEN-1:0]   operand_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            borrow;

   always_comb begin
      sum       = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      // Remainder shifted left by one, pulling in the next dividend bit.
      rem_sh    = acc_i[2*XLEN-1:XLEN-1];
      borrow    = rem_sh < {1'b0, operand_i};
      diff      = rem_sh[XLEN-1:0] - operand_i;
      operand_o = operand_i;
      if (mode_i == MODE_MUL) begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end else if (borrow) begin
         acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
         acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; result holds last value
//   CALC  | one shift-add / restoring-divide step per cycle, 32 steps
//   FIXUP | apply signs and select the result half
//   DONE  | one-cycle done pulse, then back to IDLE
module muldiv_unit
   import pkg_muldiv::*;
#(
   parameter int XLEN       = 32,
   parameter int ITERATIONS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int            CW       = $clog2(ITERATIONS);
   localparam logic [CW-1:0] CNT_LOAD = CW'(ITERATIONS - 1);

   muldiv_state_t     state_q, state_d;
   muldiv_op_t        op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   opb_step;
   muldiv_mode_t      mode;

   muldiv_op_t        op_in;
   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

   assign mode = op_q[2] ? MODE_DIV : MODE_MUL;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i     (acc_q),
      .operand_i (opb_q),
      .mode_i    (mode),
      .acc_o     (acc_step),
      .operand_o (opb_step)
   );

   always_comb begin
      op_in    = muldiv_op_t'(op);
      sign_a   = op_a_signed(op_in) & rs1_data[XLEN-1];
      sign_b   = op_b_signed(op_in) & rs2_data[XLEN-1];
      mag_a    = sign_a ? -rs1_data : rs1_data;
      mag_b    = sign_b ? -rs2_data : rs2_data;
      div_zero = op[2] && (rs2_data == '0);
      div_ovf  = ((op_in == DIV) || (op_in == REM)) &&
                 (rs1_data == MULDIV_OVF_Q) && (rs2_data == '1);
      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op_in;
               acc_d     = {{XLEN{1'b0}}, mag_a};
               opb_d     = mag_b;
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               cnt_d     = CNT_LOAD;
               if (div_zero) begin
                  result_d = op[1] ? rs1_data : MULDIV_DIVZERO_Q;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = op[1] ? '0 : MULDIV_OVF_Q;
                  state_d  = DONE;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            acc_d = acc_step;
            opb_d = opb_step;
            if (cnt_q == '0) begin
               state_d = FIXUP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIXUP: begin
            case (op_q)
               MUL:                   result_d = prod_fix[XLEN-1:0];
               MULH, MULHSU, MULHU:   result_d = prod_fix[2*XLEN-1:XLEN];
               DIV, DIVU:             result_d = quo_fix;
               default:               result_d = rem_fix;
            endcase
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         op_q      <= MUL;
         acc_q     <= '0;
         opb_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results, latency, handshake, abort.
module tb_muldiv_unit;
   import pkg_muldiv::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   muldiv_unit #(.XLEN(32), .ITERATIONS(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, " result"}, result, e);
      end
   endtask

   // Accept happens at edge 0; lat counts cycles inclusive of the accept cycle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int exp_lat);
      int   lat;
      logic busy_ok;
      exp_q.push_back(expv);
      @(negedge clk);
      op = o; rs1_data = a; rs2_data = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rs1_data = ~a; rs2_data = ~b; op = ~o;
      lat = 1; busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
      pop_check(tag);
      @(posedge clk); #1;
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
      check({tag, " result hold"}, result, expv);
   endtask

   initial begin
      int lat;
      int n_done;

      #2;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk); reset = 1'b1;

      run_op("mul 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("mul big",         MUL,    32'h1234_5678,  32'd9,         32'hA3D7_0A38, 34);
      run_op("mulh min*min",    MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhu max*max",   MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("mulhsu -1*max",   MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run_op("mulh -1*1",       MULH,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34);
      run_op("div -7/2",        DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
      run_op("rem -7%2",        REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
      run_op("div 7/-2",        DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      run_op("rem 7%-2",        REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34);
      run_op("divu 100/7",      DIVU,   32'd100,        32'd7,         32'd14,        34);
      run_op("remu 100%7",      REMU,   32'd100,        32'd7,         32'd2,         34);
      run_op("divu min/max",    DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34);
      run_op("remu min%max",    REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34);
      run_op("div 5/0",         DIV,    32'd5,          32'd0,         MULDIV_DIVZERO_Q, 1);
      run_op("rem 5%0",         REM,    32'd5,          32'd0,         32'd5,         1);
      run_op("divu min/0",      DIVU,   32'h8000_0000,  32'd0,         32'hFFFF_FFFF, 1);
      run_op("remu min%0",      REMU,   32'h8000_0000,  32'd0,         32'h8000_0000, 1);
      run_op("div ovf",         DIV,    32'h8000_0000,  32'hFFFF_FFFF, MULDIV_OVF_Q,  1);
      run_op("rem ovf",         REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Start while busy must be ignored, even with new operands on the ports.
      exp_q.push_back(32'd12);
      @(negedge clk);
      op = MUL; rs1_data = 32'd3; rs2_data = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == 9) begin
            op = DIV; rs1_data = 32'd100; rs2_data = 32'd7; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("ignored start latency", 32'(lat), 32'd34);
      pop_check("ignored start");
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("ignored start extra done", 32'(n_done), 32'd0);

      // Reset mid-operation aborts with no partial result.
      @(negedge clk);
      op = MUL; rs1_data = 32'd5; rs2_data = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort result", result, 32'd0);
      @(negedge clk); reset = 1'b1;
      n_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("abort no done", 32'(n_done), 32'd0);
      check("abort result held", result, 32'd0);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
